// File: rtl/lane_car_counter.sv
// lane_car_counter
// Per-lane vehicle queue tracker. Each lane keeps a saturating car count that
// increments on an arrival pulse and, while the lane's light is green, drains
// one car every DRAIN_PERIOD cycles. All outputs come straight from registers.
//
// Optional feature: define LANE_CAR_COUNTER_OVF_EN to get a sticky per-lane
// overflow flag (set when an arrival hits a lane already at maximum count).
// Without it the overflow bus is tied to zero and no flag registers exist.
//
// Lane index order: N1,N2,E1,E2,S1,S2,W1,W2 (bit 0 = N1).

module lane_car_counter #(
   parameter int LANES        = 8,
   parameter int CNT_W        = 8,
   parameter int DRAIN_PERIOD = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [LANES-1:0]       carArrive,
   input  logic [LANES-1:0]       laneGreen,
   output logic [LANES*CNT_W-1:0] carCounts,
   output logic [LANES-1:0]       carDepart,
   output logic [LANES-1:0]       overflow
);

   // Drain timer only has to reach DRAIN_PERIOD-1; keep at least one bit so
   // the DRAIN_PERIOD=1 case still has a legal (always-zero) register.
   localparam int TMR_W = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;

   // Timer value at which the current green period releases a car.
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_PERIOD - 1);

   // Count value at which further arrivals are dropped.
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane

         logic [CNT_W-1:0] r_cnt;
         logic [TMR_W-1:0] r_tmr;
         logic             r_dep;

         logic w_arr;
         logic w_active;
         logic w_dep;
         logic w_sat;

         // A lane is draining only while green with cars waiting; the timer
         // is meaningless otherwise and is held at zero so each new green
         // period (or newly non-empty green lane) starts a full period.
         assign w_arr    = carArrive[gi];
         assign w_active = laneGreen[gi] && (r_cnt != '0);
         assign w_dep    = w_active && (r_tmr == TMR_LAST);
         assign w_sat    = (r_cnt == CNT_MAX);

         // Drain timer: counts green cycles, wraps on each departure.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_tmr <= '0;
            end else if (!w_active) begin
               r_tmr <= '0;
            end else if (w_dep) begin
               r_tmr <= '0;
            end else begin
               r_tmr <= r_tmr + 1'b1;
            end
         end

         // Queue length: arrivals add, departures subtract, both cancel.
         // Departure is never generated at zero, so no underflow guard needed.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_cnt <= '0;
            end else begin
               unique case ({w_arr, w_dep})
                  2'b10: begin
                     if (!w_sat) begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
                  2'b01: begin
                     r_cnt <= r_cnt - 1'b1;
                  end
                  default: begin
                     r_cnt <= r_cnt;
                  end
               endcase
            end
         end

         // Departure pulse, aligned with the decremented count.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_dep <= 1'b0;
            end else begin
               r_dep <= w_dep;
            end
         end

         assign carCounts[CNT_W*gi +: CNT_W] = r_cnt;
         assign carDepart[gi]                = r_dep;

`ifdef LANE_CAR_COUNTER_OVF_EN
         logic r_ovf;

         // Sticky overflow: an arrival was dropped because the lane was full
         // and nothing left that cycle to make room. Cleared only by reset.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_ovf <= 1'b0;
            end else if (w_arr && !w_dep && w_sat) begin
               r_ovf <= 1'b1;
            end
         end

         assign overflow[gi] = r_ovf;
`endif

      end
   endgenerate

`ifndef LANE_CAR_COUNTER_OVF_EN
   assign overflow = '0;
`endif

endmodule

// File: tb/tb_lane_car_counter.sv
// Directed testbench for lane_car_counter (default parameters: 8 lanes,
// 8-bit counts, DRAIN_PERIOD = 4). Inputs change and outputs are sampled
// 1 time unit after each rising edge.

module tb_lane_car_counter;

   localparam int LANES = 8;
   localparam int CNT_W = 8;

   logic                   clk;
   logic                   rst;
   logic [LANES-1:0]       carArrive;
   logic [LANES-1:0]       laneGreen;
   logic [LANES*CNT_W-1:0] carCounts;
   logic [LANES-1:0]       carDepart;
   logic [LANES-1:0]       overflow;

   int n_cmp;
   int n_err;

   lane_car_counter #(
      .LANES        (LANES),
      .CNT_W        (CNT_W),
      .DRAIN_PERIOD (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .carArrive (carArrive),
      .laneGreen (laneGreen),
      .carCounts (carCounts),
      .carDepart (carDepart),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CNT_W-1:0] lane_cnt(input int i);
      return carCounts[CNT_W*i +: CNT_W];
   endfunction

   task automatic do_reset();
      rst       = 1'b1;
      carArrive = '0;
      laneGreen = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      carArrive = 8'hFF;
      laneGreen = 8'hFF;
      tick();
      tick();
      carArrive = '0;
      laneGreen = '0;
      rst       = 1'b0;
      tick();
      n_cmp++;
      if (carCounts !== 64'h0) begin
         n_err++;
         $display("FAIL reset_counts got=%h exp=%h", carCounts, 64'h0);
      end
      n_cmp++;
      if (carDepart !== 8'h00) begin
         n_err++;
         $display("FAIL reset_depart got=%h exp=%h", carDepart, 8'h00);
      end
      n_cmp++;
      if (overflow !== 8'h00) begin
         n_err++;
         $display("FAIL reset_overflow got=%h exp=%h", overflow, 8'h00);
      end
      $display("test_reset: counts=%h depart=%h overflow=%h", carCounts, carDepart, overflow);
   endtask

   task automatic test_arrivals();
      do_reset();
      carArrive = 8'h04;
      for (int n = 1; n <= 5; n++) begin
         tick();
         n_cmp++;
         if (lane_cnt(2) !== CNT_W'(n)) begin
            n_err++;
            $display("FAIL arrivals_e1 step=%0d got=%0d exp=%0d", n, lane_cnt(2), n);
         end
         n_cmp++;
         if (carDepart !== 8'h00) begin
            n_err++;
            $display("FAIL arrivals_depart step=%0d got=%h exp=00", n, carDepart);
         end
      end
      carArrive = '0;
      tick();
      n_cmp++;
      if (carCounts !== 64'h0000_0000_0005_0000) begin
         n_err++;
         $display("FAIL arrivals_bus got=%h exp=%h", carCounts, 64'h0000_0000_0005_0000);
      end
      $display("test_arrivals: counts=%h", carCounts);
   endtask

   task automatic test_drain();
      logic [7:0] exp_cnt;
      logic       exp_dep;
      do_reset();
      carArrive = 8'h01;
      tick(); tick(); tick();
      carArrive = '0;
      laneGreen = 8'h01;
      // j = number of edges after edge k (j=0 is edge k itself)
      for (int j = 0; j < 16; j++) begin
         tick();
         exp_dep = (j == 3) || (j == 7) || (j == 11);
         exp_cnt = (j < 3) ? 8'd3 : (j < 7) ? 8'd2 : (j < 11) ? 8'd1 : 8'd0;
         n_cmp++;
         if (carDepart !== {7'b0, exp_dep}) begin
            n_err++;
            $display("FAIL drain_depart j=%0d got=%h exp=%h", j, carDepart, {7'b0, exp_dep});
         end
         n_cmp++;
         if (lane_cnt(0) !== exp_cnt) begin
            n_err++;
            $display("FAIL drain_count j=%0d got=%0d exp=%0d", j, lane_cnt(0), exp_cnt);
         end
         $display("test_drain: j=%0d n1=%0d depart=%h", j, lane_cnt(0), carDepart);
      end
      laneGreen = '0;
   endtask

   task automatic test_simultaneous();
      logic [7:0] exp_tab [12];
      logic       exp_dep;
      exp_tab = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd5, 8'd6, 8'd7, 8'd7, 8'd8, 8'd9, 8'd10, 8'd10};
      do_reset();
      carArrive = 8'h80;
      tick(); tick(); tick(); tick();
      carArrive = '0;
      laneGreen = 8'h80;
      for (int j = 0; j < 12; j++) begin
         // arrivals held from edge k+3 onward, coinciding with first departure
         if (j == 3) carArrive = 8'h80;
         tick();
         exp_dep = (j == 3) || (j == 7) || (j == 11);
         n_cmp++;
         if (carDepart !== {exp_dep, 7'b0}) begin
            n_err++;
            $display("FAIL simul_depart j=%0d got=%h exp=%h", j, carDepart, {exp_dep, 7'b0});
         end
         n_cmp++;
         if (lane_cnt(7) !== exp_tab[j]) begin
            n_err++;
            $display("FAIL simul_count j=%0d got=%0d exp=%0d", j, lane_cnt(7), exp_tab[j]);
         end
         $display("test_simultaneous: j=%0d w2=%0d depart=%h", j, lane_cnt(7), carDepart);
      end
      carArrive = '0;
      laneGreen = '0;
   endtask

   task automatic test_saturation();
      logic [7:0] exp_ovf;
`ifdef LANE_CAR_COUNTER_OVF_EN
      exp_ovf = 8'h20;
`else
      exp_ovf = 8'h00;
`endif
      do_reset();
      carArrive = 8'h20;
      for (int n = 0; n < 255; n++) tick();
      n_cmp++;
      if (lane_cnt(5) !== 8'd255) begin
         n_err++;
         $display("FAIL sat_full got=%0d exp=255", lane_cnt(5));
      end
      n_cmp++;
      if (overflow !== 8'h00) begin
         n_err++;
         $display("FAIL sat_no_ovf_yet got=%h exp=00", overflow);
      end
      tick();
      carArrive = '0;
      n_cmp++;
      if (lane_cnt(5) !== 8'd255) begin
         n_err++;
         $display("FAIL sat_hold got=%0d exp=255", lane_cnt(5));
      end
      n_cmp++;
      if (overflow !== exp_ovf) begin
         n_err++;
         $display("FAIL sat_ovf got=%h exp=%h", overflow, exp_ovf);
      end
      tick(); tick();
      n_cmp++;
      if (overflow !== exp_ovf) begin
         n_err++;
         $display("FAIL sat_ovf_sticky got=%h exp=%h", overflow, exp_ovf);
      end
      $display("test_saturation: s2=%0d overflow=%h", lane_cnt(5), overflow);
      do_reset();
      n_cmp++;
      if (overflow !== 8'h00 || carCounts !== 64'h0) begin
         n_err++;
         $display("FAIL sat_reset ovf=%h counts=%h exp ovf=00 counts=0", overflow, carCounts);
      end
   endtask

   task automatic test_green_glitch();
      do_reset();
      carArrive = 8'h08;
      tick(); tick();
      carArrive = '0;
      laneGreen = 8'h08;
      tick(); tick();
      laneGreen = '0;
      tick();
      laneGreen = 8'h08;
      for (int j = 0; j < 4; j++) begin
         tick();
         n_cmp++;
         if (carDepart[3] !== (j == 3)) begin
            n_err++;
            $display("FAIL glitch_depart j=%0d got=%b exp=%b", j, carDepart[3], (j == 3));
         end
         n_cmp++;
         if (lane_cnt(3) !== ((j == 3) ? 8'd1 : 8'd2)) begin
            n_err++;
            $display("FAIL glitch_count j=%0d got=%0d exp=%0d", j, lane_cnt(3), (j == 3) ? 1 : 2);
         end
         $display("test_green_glitch: j=%0d e2=%0d depart=%h", j, lane_cnt(3), carDepart);
      end
      laneGreen = '0;
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      carArrive = 8'h11;
      tick(); tick(); tick();
      carArrive = '0;
      laneGreen = 8'h11;
      tick(); tick(); tick();
      rst       = 1'b1;
      carArrive = 8'hFF;
      tick();
      rst       = 1'b0;
      carArrive = '0;
      n_cmp++;
      if (carCounts !== 64'h0 || carDepart !== 8'h00) begin
         n_err++;
         $display("FAIL mid_drain_reset counts=%h depart=%h exp counts=0 depart=00", carCounts, carDepart);
      end
      $display("test_reset_mid_drain: counts=%h depart=%h", carCounts, carDepart);
      laneGreen = '0;
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst       = 1'b1;
      carArrive = '0;
      laneGreen = '0;
      test_reset();
      test_arrivals();
      test_drain();
      test_simultaneous();
      test_saturation();
      test_green_glitch();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
